// File: rtl/xsw_pkg.sv
// xsw_pkg: shared types for the switch ingress slice.
// Burst FSM state enum and level-width helper.
package xsw_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Occupancy counter must reach DEPTH itself, hence the extra bit.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/xsw_if.sv
// xsw_if: upstream beat channel plus switch-port channel of one ingress.
// master drives vld_i/pld_i/gnt_o; slave (ingress) drives the rest.
interface xsw_if #(
  parameter int P = 10
);

  logic         vld_i;
  logic [P-1:0] pld_i;
  logic         gnt_i;
  logic         vld_o;
  logic [P-1:0] pld_o;
  logic         gnt_o;
  logic         ocy_o;
  logic         rel_o;

  modport master (
    output vld_i, pld_i, gnt_o,
    input  gnt_i, vld_o, pld_o, ocy_o, rel_o
  );

  modport slave (
    input  vld_i, pld_i, gnt_o,
    output gnt_i, vld_o, pld_o, ocy_o, rel_o
  );

endinterface

// File: rtl/xsw_fifo.sv
// xsw_fifo: DEPTH-entry beat FIFO with wrapping pointers and level.
// Ports: push/wdata in, pop in, rdata = head, level/lvl_nxt/empty out.
module xsw_fifo
  import xsw_pkg::*;
#(
  parameter int P     = 10,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push,
  input  logic [P-1:0]              wdata,
  input  logic                      pop,
  output logic [P-1:0]              rdata,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [lvl_w(DEPTH)-1:0]   lvl_nxt,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [P-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          wr;
  logic          rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign rdata = mem[rptr];

  always_comb begin
    lvl_nxt = level;
    unique case ({wr, rd})
      2'b10:   lvl_nxt = level + 1'b1;
      2'b01:   lvl_nxt = level - 1'b1;
      default: lvl_nxt = level;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      level <= lvl_nxt;
    end
  end

endmodule

// File: rtl/xsw_ingress.sv
// xsw_ingress: buffers upstream beats and frames bursts for a switch port.
// Ports: clk, rstn, bus (xsw_if.slave), level = FIFO occupancy.
module xsw_ingress
  import xsw_pkg::*;
#(
  parameter int P       = 10,
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 2,
  parameter int LEN_LSB = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  xsw_if.slave                    bus,
  output logic [lvl_w(DEPTH)-1:0] level
);

  localparam int LW = lvl_w(DEPTH);

  logic             gnt_q;
  logic             push;
  logic             pop;
  logic             empty;
  logic             vld;
  logic [P-1:0]     head;
  logic [LW-1:0]    lvl_nxt;
  logic [LEN_W-1:0] hd_len;
  logic             last;
  logic             ocy;
  logic             rel;

  state_t           state_q;
  state_t           state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;

  assign push = bus.vld_i & gnt_q;
  assign vld  = ~empty;
  assign pop  = vld & bus.gnt_o;

  xsw_fifo #(
    .P     (P),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push),
    .wdata   (bus.pld_i),
    .pop     (pop),
    .rdata   (head),
    .level   (level),
    .lvl_nxt (lvl_nxt),
    .empty   (empty)
  );

  // Ready looks one cycle ahead so a full FIFO never sees a push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) gnt_q <= 1'b0;
    else       gnt_q <= (lvl_nxt < LW'(DEPTH));
  end

  assign hd_len = head[LEN_LSB +: LEN_W];
  assign last   = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ocy     = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ocy = vld;
        rel = vld & (hd_len == '0);
        if (pop && hd_len != '0) begin
          state_d = BURST;
          cnt_d   = LEN_W'(1);
          len_d   = hd_len;
        end
      end
      BURST: begin
        rel = vld & last;
        if (pop) begin
          if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign bus.gnt_i = gnt_q;
  assign bus.vld_o = vld;
  assign bus.pld_o = head;
  assign bus.ocy_o = ocy;
  assign bus.rel_o = rel;

endmodule

// File: tb/tb_xsw_ingress.sv
// tb_xsw_ingress: directed checks of the ingress FIFO and burst framing.
// DUT at P=10, DEPTH=4, LEN_W=2, LEN_LSB=0.
module tb_xsw_ingress;
  import xsw_pkg::*;

  logic       clk;
  logic       rstn;
  logic [2:0] level;
  int         n_chk;
  int         n_fail;

  xsw_if #(.P(10)) bus ();

  xsw_ingress #(
    .P       (10),
    .DEPTH   (4),
    .LEN_W   (2),
    .LEN_LSB (0)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus),
    .level (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic vo,
                      input logic oc, input logic rl);
    chk({tag, ".vld_o"}, 32'(bus.vld_o), 32'(vo));
    chk({tag, ".ocy_o"}, 32'(bus.ocy_o), 32'(oc));
    chk({tag, ".rel_o"}, 32'(bus.rel_o), 32'(rl));
  endtask

  logic [9:0] drn [4];

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    rstn       = 1'b0;
    bus.vld_i  = 1'b0;
    bus.pld_i  = '0;
    bus.gnt_o  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    outs("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.gnt_i", 32'(bus.gnt_i), 32'd0);
    chk("rst.level", 32'(level), 32'd0);
    rstn = 1'b1;
    tick();
    chk("rel.gnt_i", 32'(bus.gnt_i), 32'd1);

    // Single-beat burst
    bus.gnt_o = 1'b1;
    bus.vld_i = 1'b1;
    bus.pld_i = 10'h000;
    tick();
    bus.vld_i = 1'b0;
    outs("single", 1'b1, 1'b1, 1'b1);
    chk("single.level", 32'(level), 32'd1);
    tick();
    chk("single.level0", 32'(level), 32'd0);
    outs("single.done", 1'b0, 1'b0, 1'b0);

    // Three-beat burst, later length fields are junk
    bus.vld_i = 1'b1;
    bus.pld_i = 10'h102;
    tick();
    chk("b3.pld0", 32'(bus.pld_o), 32'h102);
    outs("b3.beat0", 1'b1, 1'b1, 1'b0);
    chk("b3.st0", 32'(dut.state_q), 32'(IDLE));
    bus.pld_i = 10'h0B1;
    tick();
    chk("b3.pld1", 32'(bus.pld_o), 32'h0B1);
    outs("b3.beat1", 1'b1, 1'b0, 1'b0);
    chk("b3.st1", 32'(dut.state_q), 32'(BURST));
    bus.pld_i = 10'h0C3;
    tick();
    chk("b3.pld2", 32'(bus.pld_o), 32'h0C3);
    outs("b3.beat2", 1'b1, 1'b0, 1'b1);
    chk("b3.st2", 32'(dut.state_q), 32'(BURST));
    bus.vld_i = 1'b0;
    tick();
    chk("b3.st3", 32'(dut.state_q), 32'(IDLE));
    chk("b3.level", 32'(level), 32'd0);

    // Fill to full with the switch stalled, fifth beat held
    bus.gnt_o = 1'b0;
    bus.vld_i = 1'b1;
    bus.pld_i = 10'h040;
    tick();
    bus.pld_i = 10'h080;
    tick();
    bus.pld_i = 10'h0C0;
    tick();
    bus.pld_i = 10'h100;
    tick();
    chk("full.level", 32'(level), 32'd4);
    chk("full.gnt_i", 32'(bus.gnt_i), 32'd0);
    bus.pld_i = 10'h140;
    tick();
    chk("full.held", 32'(level), 32'd4);
    chk("full.head", 32'(bus.pld_o), 32'h040);
    bus.gnt_o = 1'b1;
    tick();
    bus.gnt_o = 1'b0;
    chk("full.pop", 32'(level), 32'd3);
    chk("full.gnt_up", 32'(bus.gnt_i), 32'd1);
    chk("full.head2", 32'(bus.pld_o), 32'h080);
    tick();
    bus.vld_i = 1'b0;
    chk("full.fifth", 32'(level), 32'd4);
    chk("full.gnt_dn", 32'(bus.gnt_i), 32'd0);
    drn[0] = 10'h080;
    drn[1] = 10'h0C0;
    drn[2] = 10'h100;
    drn[3] = 10'h140;
    bus.gnt_o = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain.pld%0d", i), 32'(bus.pld_o), 32'(drn[i]));
      tick();
    end
    chk("drain.level", 32'(level), 32'd0);

    // Steady push+pop at level 2 across pointer wrap
    bus.gnt_o = 1'b0;
    bus.vld_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.pld_i = 10'((k + 1) * 4);
      tick();
    end
    bus.gnt_o = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.pld_i = 10'((k + 3) * 4);
      chk($sformatf("wrap.level%0d", k), 32'(level), 32'd2);
      chk($sformatf("wrap.pld%0d", k), 32'(bus.pld_o),
          32'((k + 1) * 4));
      tick();
    end
    bus.vld_i = 1'b0;
    chk("wrap.level_end", 32'(level), 32'd2);
    tick();
    tick();
    chk("wrap.empty", 32'(level), 32'd0);

    // Four-beat burst with an upstream gap after beat 1
    bus.vld_i = 1'b1;
    bus.pld_i = 10'h203;
    tick();
    outs("gap.beat0", 1'b1, 1'b1, 1'b0);
    bus.pld_i = 10'h210;
    tick();
    outs("gap.beat1", 1'b1, 1'b0, 1'b0);
    bus.vld_i = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      outs($sformatf("gap.idle%0d", g), 1'b0, 1'b0, 1'b0);
      chk($sformatf("gap.st%0d", g), 32'(dut.state_q), 32'(BURST));
    end
    bus.vld_i = 1'b1;
    bus.pld_i = 10'h222;
    tick();
    outs("gap.beat2", 1'b1, 1'b0, 1'b0);
    bus.pld_i = 10'h233;
    tick();
    outs("gap.beat3", 1'b1, 1'b0, 1'b1);
    bus.vld_i = 1'b0;
    tick();
    chk("gap.st_end", 32'(dut.state_q), 32'(IDLE));

    // Reset in the middle of a burst with three beats queued
    bus.vld_i = 1'b1;
    bus.pld_i = 10'h303;
    tick();
    bus.pld_i = 10'h311;
    tick();
    bus.gnt_o = 1'b0;
    bus.pld_i = 10'h322;
    tick();
    bus.pld_i = 10'h333;
    tick();
    bus.vld_i = 1'b0;
    chk("mid.level", 32'(level), 32'd3);
    chk("mid.st", 32'(dut.state_q), 32'(BURST));
    rstn = 1'b0;
    #1;
    outs("mid.rst", 1'b0, 1'b0, 1'b0);
    chk("mid.rst.gnt_i", 32'(bus.gnt_i), 32'd0);
    chk("mid.rst.level", 32'(level), 32'd0);
    chk("mid.rst.st", 32'(dut.state_q), 32'(IDLE));
    tick();
    rstn = 1'b1;
    tick();
    chk("post.gnt_i", 32'(bus.gnt_i), 32'd1);
    bus.gnt_o = 1'b1;
    bus.vld_i = 1'b1;
    bus.pld_i = 10'h101;
    tick();
    outs("post.beat0", 1'b1, 1'b1, 1'b0);
    chk("post.level", 32'(level), 32'd1);
    bus.pld_i = 10'h1F2;
    tick();
    outs("post.beat1", 1'b1, 1'b0, 1'b1);
    bus.vld_i = 1'b0;
    tick();
    chk("post.st", 32'(dut.state_q), 32'(IDLE));
    chk("post.empty", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
